// File: rtl/botassium_mem_stream_writer.sv
// botassium_mem_stream_writer: packs bytes into little-endian words, logs them to a
// circular region of the dual-port RAM and updates a status word after each data write.
module botassium_mem_stream_writer #(
    parameter int ADDR_W      = 7,
    parameter int STATUS_ADDR = 127
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [ADDR_W-1:0] address2,
    output logic [3:0]        byteenable2,
    output logic              chipselect2,
    output logic              write2,
    output logic [31:0]       writedata2,
    output logic              clken2,
    output logic              irq
);
    typedef enum logic [1:0] {PACK, WR_DATA, WR_STAT} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(STATUS_ADDR - 1);
    localparam logic [ADDR_W-1:0] STAT = ADDR_W'(STATUS_ADDR);
    state_t state, state_nxt;
    logic [2:0] byte_cnt, cnt_nxt;
    logic [31:0] pack, pack_nxt, status;
    logic [ADDR_W-1:0] wr_ptr, ptr_nxt;
    logic [15:0] word_count, count_nxt;
    logic [3:0] be_nxt;
    logic wrap, wrap_nxt, xfer;
    assign in_ready = reset_n & enable & (state == PACK);
    assign xfer     = in_valid & in_ready;
    assign clken2   = 1'b1;
    assign be_nxt   = 4'hF >> (3'd4 - cnt_nxt);
    // byte_cnt still holds the lane count of the word just written while in WR_DATA
    assign status   = {count_nxt, 5'b0, byte_cnt, wrap_nxt, 7'(ptr_nxt)};
    always_comb begin
        state_nxt = state;
        cnt_nxt   = byte_cnt;
        pack_nxt  = pack;
        ptr_nxt   = wr_ptr;
        count_nxt = word_count;
        wrap_nxt  = wrap;
        case (state)
            PACK: begin
                if (xfer) begin
                    cnt_nxt = byte_cnt + 3'd1;
                    pack_nxt[{byte_cnt[1:0], 3'b000} +: 8] = in_data;
                end
                if (cnt_nxt == 3'd4 || (flush && cnt_nxt != 3'd0)) state_nxt = WR_DATA;
            end
            WR_DATA: begin
                state_nxt = WR_STAT;
                ptr_nxt   = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                wrap_nxt  = wrap | (wr_ptr == LAST);
                count_nxt = word_count + 16'd1;
            end
            default: begin
                state_nxt = PACK;
                cnt_nxt   = '0;
                pack_nxt  = '0;
            end
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= PACK;
        else state <= state_nxt;
    end
    // memory-side outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt    <= '0;
            pack        <= '0;
            wr_ptr      <= '0;
            word_count  <= '0;
            wrap        <= 1'b0;
            chipselect2 <= 1'b0;
            write2      <= 1'b0;
            address2    <= '0;
            byteenable2 <= '0;
            writedata2  <= '0;
            irq         <= 1'b0;
        end else begin
            byte_cnt    <= cnt_nxt;
            pack        <= pack_nxt;
            wr_ptr      <= ptr_nxt;
            word_count  <= count_nxt;
            wrap        <= wrap_nxt;
            chipselect2 <= state_nxt != PACK;
            write2      <= state_nxt != PACK;
            address2    <= (state_nxt == WR_STAT) ? STAT : wr_ptr;
            byteenable2 <= (state_nxt == WR_STAT) ? 4'hF : be_nxt;
            writedata2  <= (state_nxt == WR_STAT) ? status : pack_nxt;
            irq         <= state == WR_STAT;
        end
    end
endmodule

// File: tb/tb_botassium_mem_stream_writer.sv
// tb_botassium_mem_stream_writer: directed scenarios for the byte-packing log writer.
module tb_botassium_mem_stream_writer;
    logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, in_valid = 1'b0, flush = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_ready, chipselect2, write2, clken2, irq;
    logic [6:0] address2;
    logic [3:0] byteenable2;
    logic [31:0] writedata2;
    int n_cmp = 0, n_err = 0, n_wr = 0, n_irq = 0;
    logic [6:0] d_addr = '0;
    logic [31:0] d_data = '0, s_data = '0;

    botassium_mem_stream_writer dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .address2(address2), .byteenable2(byteenable2),
        .chipselect2(chipselect2), .write2(write2), .writedata2(writedata2), .clken2(clken2), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (irq) n_irq++;
        if (chipselect2 && write2) begin
            n_wr++;
            if (address2 == 7'd127) s_data = writedata2;
            else begin
                d_addr = address2;
                d_data = writedata2;
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; enable = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic put(input logic [7:0] b);
        in_data = b; in_valid = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL put_timeout in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, irq, chipselect2, write2, address2, byteenable2, writedata2, clken2} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 4'd0, 32'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_outputs got rdy=%b irq=%b cs=%b wr=%b a=%0d be=%h d=%h ck=%b required 0,0,0,0,0,0,0,1",
                     in_ready, irq, chipselect2, write2, address2, byteenable2, writedata2, clken2);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_word();
        do_reset();
        put(8'h11); put(8'h22); put(8'h33); put(8'h44);
        n_cmp++;
        if ({in_ready, chipselect2, write2, address2, byteenable2, writedata2} !== {1'b0, 1'b1, 1'b1, 7'd0, 4'hF, 32'h44332211}) begin
            n_err++;
            $display("FAIL full_wr_data got rdy=%b cs=%b wr=%b a=%0d be=%h d=%h required 0,1,1,0,f,44332211",
                     in_ready, chipselect2, write2, address2, byteenable2, writedata2);
        end
        @(negedge clk);
        n_cmp++;
        if ({in_ready, chipselect2, write2, address2, byteenable2, writedata2} !== {1'b0, 1'b1, 1'b1, 7'd127, 4'hF, 32'h00010401}) begin
            n_err++;
            $display("FAIL full_wr_stat got rdy=%b cs=%b wr=%b a=%0d be=%h d=%h required 0,1,1,127,f,00010401",
                     in_ready, chipselect2, write2, address2, byteenable2, writedata2);
        end
        @(negedge clk);
        n_cmp++;
        if ({in_ready, irq, chipselect2} !== 3'b110) begin
            n_err++;
            $display("FAIL full_back_to_pack got rdy/irq/cs=%b required 110", {in_ready, irq, chipselect2});
        end
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL full_irq_pulse got irq=%b required 0", irq);
        end
    endtask

    task automatic test_flush();
        int w0, i0;
        do_reset();
        put(8'hAA); put(8'hBB);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++;
        if ({chipselect2, write2, address2, byteenable2, writedata2} !== {1'b1, 1'b1, 7'd0, 4'b0011, 32'h0000BBAA}) begin
            n_err++;
            $display("FAIL flush_wr_data got cs=%b wr=%b a=%0d be=%b d=%h required 1,1,0,0011,0000bbaa",
                     chipselect2, write2, address2, byteenable2, writedata2);
        end
        @(negedge clk);
        n_cmp++;
        if ({address2, writedata2} !== {7'd127, 32'h00010201}) begin
            n_err++;
            $display("FAIL flush_status got a=%0d d=%h required 127,00010201", address2, writedata2);
        end
        repeat (2) @(negedge clk);
        #1;
        w0 = n_wr; i0 = n_irq;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        n_cmp++;
        if ((n_wr - w0) !== 0 || (n_irq - i0) !== 0) begin
            n_err++;
            $display("FAIL flush_empty got writes=%0d irqs=%0d required 0,0", n_wr - w0, n_irq - i0);
        end
    endtask

    task automatic test_flush_same_cycle();
        do_reset();
        put(8'h01); put(8'h02);
        in_data = 8'hCC; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        n_cmp++;
        if ({address2, byteenable2, writedata2} !== {7'd0, 4'b0111, 32'h00CC0201}) begin
            n_err++;
            $display("FAIL flush_xfer_data got a=%0d be=%b d=%h required 0,0111,00cc0201", address2, byteenable2, writedata2);
        end
        @(negedge clk);
        n_cmp++;
        if (writedata2 !== 32'h00010301) begin
            n_err++;
            $display("FAIL flush_xfer_status got %h required 00010301", writedata2);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back_wrap();
        int w0;
        do_reset();
        #1;
        w0 = n_wr;
        for (int i = 0; i < 127; i++)
            for (int j = 0; j < 4; j++) put(8'(4 * i + j));
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({d_addr, d_data} !== {7'd126, 32'hFBFAF9F8}) begin
            n_err++;
            $display("FAIL wrap_last_data got a=%0d d=%h required 126,fbfaf9f8", d_addr, d_data);
        end
        n_cmp++;
        if (s_data !== 32'h007F0480) begin
            n_err++;
            $display("FAIL wrap_status got %h required 007f0480", s_data);
        end
        n_cmp++;
        if ((n_wr - w0) !== 254) begin
            n_err++;
            $display("FAIL wrap_write_count got %0d required 254", n_wr - w0);
        end
        put(8'hDE); put(8'hAD); put(8'hBE); put(8'hEF);
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({d_addr, d_data, s_data} !== {7'd0, 32'hEFBEADDE, 32'h00800481}) begin
            n_err++;
            $display("FAIL wrap_next got a=%0d d=%h s=%h required 0,efbeadde,00800481", d_addr, d_data, s_data);
        end
    endtask

    task automatic test_enable();
        int w0;
        do_reset();
        #1;
        w0 = n_wr;
        enable = 1'b0; in_data = 8'h5A; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL enable_low_ready cycle %0d got %b required 0", i, in_ready);
            end
        end
        #1;
        n_cmp++;
        if ((n_wr - w0) !== 0) begin
            n_err++;
            $display("FAIL enable_low_writes got %0d required 0", n_wr - w0);
        end
        enable = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL enable_high_ready got %b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++;
        if ({byteenable2, writedata2} !== {4'b0001, 32'h0000005A}) begin
            n_err++;
            $display("FAIL enable_accept got be=%b d=%h required 0001,0000005a", byteenable2, writedata2);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        put(8'h77); put(8'h88);
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, irq, chipselect2, write2, address2, byteenable2, writedata2, clken2} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 4'd0, 32'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_mid_outputs got rdy=%b irq=%b cs=%b wr=%b a=%0d be=%h d=%h ck=%b required 0,0,0,0,0,0,0,1",
                     in_ready, irq, chipselect2, write2, address2, byteenable2, writedata2, clken2);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        put(8'h01); put(8'h02); put(8'h03); put(8'h04);
        n_cmp++;
        if ({address2, byteenable2, writedata2} !== {7'd0, 4'hF, 32'h04030201}) begin
            n_err++;
            $display("FAIL reset_mid_data got a=%0d be=%h d=%h required 0,f,04030201", address2, byteenable2, writedata2);
        end
        @(negedge clk);
        n_cmp++;
        if (writedata2 !== 32'h00010401) begin
            n_err++;
            $display("FAIL reset_mid_status got %h required 00010401", writedata2);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_flush();
        test_flush_same_cycle();
        test_enable();
        test_reset_mid();
        test_back_to_back_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
